// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
// Holds the PC/instruction widths, the NOP word, the fetch FSM state
// encoding, the fetch-queue entry layout and the branch-target helper.
package if_stage_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP = 16'h0000;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Target = pc + 1 + sign-extended 6-bit offset, wrapping at 16 bits.
  function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc,
                                                    input logic [5:0]      off);
    return pc + 16'd1 + {{(PC_W-6){off[5]}}, off};
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: instruction-memory read channel.
//   req    - read request (master -> slave)
//   addr   - word address of the request (master -> slave)
//   gnt    - request accepted this cycle (slave -> master)
//   rvalid - read data valid, at least one cycle after gnt (slave -> master)
//   rdata  - instruction word (slave -> master)
interface if_stage_if;
  import if_stage_pkg::*;

  logic               req;
  logic [PC_W-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/if_stage_fetch_queue.sv
// fetch_queue: two-entry FIFO of {pc, instr} between fetch and decode.
//   clk, rst  - clock, synchronous active-high reset
//   push      - write push_data at the tail
//   pop       - drop the head entry
//   flush     - empty the queue (wins over push/pop)
//   push_data - entry to write
//   head      - current head entry (only meaningful when count != 0)
//   count     - number of valid entries (0..2)
module fetch_queue
  import if_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full queue still accepts a push when the head leaves the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage with a single-outstanding memory port
// and a two-entry fetch queue feeding decode.
//   clk, rst               - clock, synchronous active-high reset
//   imem                   - instruction-memory read channel (master side)
//   instruction_decode_en  - decode stall, 1 = decode holds its instruction
//   branch_taken           - decode resolved a taken branch on the presented word
//   branch_offset_imm      - signed 6-bit branch offset
//   instruction            - presented instruction, NOP when not valid
//   instruction_pc         - address of the presented instruction
//   if_valid               - instruction holds a real fetched word
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | no request outstanding; issue one when the queue has room
// WAIT  | request granted, waiting for rvalid to push the response
// DROP  | request granted but a branch flushed it; discard its response
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              FQ_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  if_stage_if.master         imem,
  input  logic               instruction_decode_en,
  input  logic               branch_taken,
  input  logic [5:0]         branch_offset_imm,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    instruction_pc,
  output logic               if_valid
);

  localparam logic [1:0] FQ_MAX = 2'(FQ_DEPTH);

  logic [1:0]      state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;
  logic [1:0]      count;
  logic [1:0]      occupancy;
  logic            outstanding;
  logic            branch_acc;
  logic            pop;
  logic            push;
  logic            grant;
  fetch_entry_t    head;
  fetch_entry_t    push_data;

  assign if_valid       = (count != 2'd0) && !rst;
  assign instruction    = if_valid ? head.instr : NOP;
  assign instruction_pc = if_valid ? head.pc : '0;

  assign pop        = if_valid && !instruction_decode_en;
  assign branch_acc = branch_taken && pop;

  // WAIT and DROP both hold a slot for the in-flight response.
  assign outstanding = (state != ST_FETCH);
  assign occupancy   = count + {1'b0, outstanding};

  assign imem.req  = (state == ST_FETCH) && !rst && (occupancy < FQ_MAX) && !branch_acc;
  assign imem.addr = fetch_pc;
  assign grant     = imem.req && imem.gnt;

  // A response coinciding with an accepted branch belongs to the old path.
  assign push      = (state == ST_WAIT) && imem.rvalid && !branch_acc;
  assign push_data = '{pc: req_pc, instr: imem.rdata};

  fetch_queue u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (branch_acc),
    .push_data (push_data),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      if (branch_acc) begin
        fetch_pc <= branch_target(instruction_pc, branch_offset_imm);
      end else if (grant) begin
        fetch_pc <= fetch_pc + 16'd1;
      end
      if (grant) begin
        req_pc <= fetch_pc;
      end
      case (state)
        ST_FETCH: if (grant) state <= ST_WAIT;
        ST_WAIT: begin
          if (imem.rvalid)     state <= ST_FETCH;
          else if (branch_acc) state <= ST_DROP;
        end
        ST_DROP:  if (imem.rvalid) state <= ST_FETCH;
        default:  state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instruction_decode_en = 1'b0;
  logic        branch_taken = 1'b0;
  logic [5:0]  branch_offset_imm = 6'd0;
  logic [15:0] instruction;
  logic [15:0] instruction_pc;
  logic        if_valid;

  int          checks = 0;
  int          passed = 0;
  int          lat = 1;
  logic [15:0] exp_pc = 16'd0;

  if_stage_if mi ();

  if_stage #(.RESET_PC(16'h0000), .FQ_DEPTH(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .imem                  (mi),
    .instruction_decode_en (instruction_decode_en),
    .branch_taken          (branch_taken),
    .branch_offset_imm     (branch_offset_imm),
    .instruction           (instruction),
    .instruction_pc        (instruction_pc),
    .if_valid              (if_valid)
  );

  always #5 clk = ~clk;

  // Memory: data word = address + 16'h1000; rvalid arrives lat cycles after grant.
  initial begin
    int          pend_cnt;
    bit          pend;
    logic [15:0] paddr;
    pend = 1'b0;
    pend_cnt = 0;
    paddr = 16'd0;
    mi.rvalid = 1'b0;
    mi.rdata = 16'd0;
    forever begin
      @(negedge clk);
      mi.rvalid = 1'b0;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mi.rvalid = 1'b1;
          mi.rdata = paddr + 16'h1000;
          pend = 1'b0;
        end
      end
      if (mi.req && mi.gnt) begin
        pend = 1'b1;
        pend_cnt = lat;
        paddr = mi.addr;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    mi.gnt = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    if (mi.req !== 1'b0) $display("FAIL reset_req: got %b want 0", mi.req); else passed++;
    checks++;
    if (if_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", if_valid); else passed++;
    checks++;
    if (instruction !== 16'h0000) $display("FAIL reset_instr: got %h want 0000", instruction); else passed++;
    checks++;
    if (instruction_pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", instruction_pc); else passed++;
    checks++;
    @(posedge clk); #1; rst = 1'b0; #1;
    if (mi.req !== 1'b1) $display("FAIL first_req: got %b want 1", mi.req); else passed++;
    checks++;
    if (mi.addr !== 16'h0000) $display("FAIL first_addr: got %h want 0000", mi.addr); else passed++;
    checks++;
    @(posedge clk); #2;
    if (mi.req !== 1'b0) $display("FAIL wait_req: got %b want 0", mi.req); else passed++;
    checks++;
    if (if_valid !== 1'b0) $display("FAIL wait_valid: got %b want 0", if_valid); else passed++;
    checks++;
    @(posedge clk); #2;
    if (if_valid !== 1'b1) $display("FAIL latency_valid: got %b want 1", if_valid); else passed++;
    checks++;
    if (instruction !== 16'h1000) $display("FAIL latency_instr: got %h want 1000", instruction); else passed++;
    checks++;
    if (instruction_pc !== 16'h0000) $display("FAIL latency_pc: got %h want 0000", instruction_pc); else passed++;
    checks++;
    exp_pc = 16'd1;
  endtask

  task automatic test_stream();
    int got = 0;
    for (int i = 0; i < 30 && got < 6; i++) begin
      @(posedge clk); #2;
      if (if_valid) begin
        if (instruction_pc !== exp_pc) $display("FAIL stream_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
        checks++;
        if (instruction !== exp_pc + 16'h1000) $display("FAIL stream_instr: got %h want %h", instruction, exp_pc + 16'h1000); else passed++;
        checks++;
        exp_pc = exp_pc + 16'd1;
        got++;
      end
    end
    if (got != 6) $display("FAIL stream_count: got %0d want 6", got); else passed++;
    checks++;
  endtask

  task automatic test_stall();
    int got = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b1; #1;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      if (mi.req !== 1'b0) $display("FAIL stall_req: got %b want 0", mi.req); else passed++;
      checks++;
      if (if_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", if_valid); else passed++;
      checks++;
      if (instruction_pc !== exp_pc) $display("FAIL stall_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
      checks++;
      if (instruction !== exp_pc + 16'h1000) $display("FAIL stall_instr: got %h want %h", instruction, exp_pc + 16'h1000); else passed++;
      checks++;
    end
    for (int i = 0; i < 30 && got < 4; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b0; #1;
      if (if_valid) begin
        if (instruction_pc !== exp_pc) $display("FAIL release_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
        checks++;
        if (instruction !== exp_pc + 16'h1000) $display("FAIL release_instr: got %h want %h", instruction, exp_pc + 16'h1000); else passed++;
        checks++;
        exp_pc = exp_pc + 16'd1;
        got++;
      end
    end
    if (got != 4) $display("FAIL release_count: got %0d want 4", got); else passed++;
    checks++;
  endtask

  task automatic test_branch();
    bit found = 1'b0;
    bit seen_req = 1'b0;
    int got = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b0; branch_taken = 1'b0; #1;
      if (if_valid) begin
        if (instruction_pc !== exp_pc) $display("FAIL branch_pre_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
        checks++;
        if (instruction_pc === 16'h0010) found = 1'b1;
        else exp_pc = exp_pc + 16'd1;
      end
    end
    if (!found) $display("FAIL branch_find: got no pc 0010 want pc 0010"); else passed++;
    checks++;
    branch_taken = 1'b1;
    branch_offset_imm = 6'b111100;
    #1;
    if (mi.req !== 1'b0) $display("FAIL branch_req_block: got %b want 0", mi.req); else passed++;
    checks++;
    @(posedge clk); #1; branch_taken = 1'b0; #1;
    if (if_valid !== 1'b0) $display("FAIL branch_flush: got %b want 0", if_valid); else passed++;
    checks++;
    exp_pc = 16'h000D;
    for (int i = 0; i < 30 && got < 3; i++) begin
      if (i != 0) begin
        @(posedge clk); #2;
      end
      if (mi.req && !seen_req) begin
        seen_req = 1'b1;
        if (mi.addr !== 16'h000D) $display("FAIL branch_target_addr: got %h want 000D", mi.addr); else passed++;
        checks++;
      end
      if (if_valid) begin
        if (instruction_pc !== exp_pc) $display("FAIL branch_post_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
        checks++;
        if (instruction !== exp_pc + 16'h1000) $display("FAIL branch_post_instr: got %h want %h", instruction, exp_pc + 16'h1000); else passed++;
        checks++;
        exp_pc = exp_pc + 16'd1;
        got++;
      end
    end
    if (got != 3) $display("FAIL branch_post_count: got %0d want 3", got); else passed++;
    checks++;
  endtask

  task automatic test_branch_wait();
    bit          found = 1'b0;
    bit          seen_req = 1'b0;
    bit          done = 1'b0;
    logic [15:0] target;
    lat = 3;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b1; #1;
      if (mi.req && if_valid) found = 1'b1;
    end
    if (!found) $display("FAIL bw_find: got no grant want grant with valid head"); else passed++;
    checks++;
    if (instruction_pc !== exp_pc) $display("FAIL bw_head_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
    checks++;
    target = exp_pc + 16'd3;
    @(posedge clk); #1;
    instruction_decode_en = 1'b0;
    branch_taken = 1'b1;
    branch_offset_imm = 6'b000010;
    #1;
    if (mi.req !== 1'b0) $display("FAIL bw_wait_req: got %b want 0", mi.req); else passed++;
    checks++;
    if (if_valid !== 1'b1) $display("FAIL bw_wait_valid: got %b want 1", if_valid); else passed++;
    checks++;
    @(posedge clk); #1; branch_taken = 1'b0; lat = 1; #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i != 0) begin
        @(posedge clk); #2;
      end
      if (mi.req && !seen_req) begin
        seen_req = 1'b1;
        if (mi.addr !== target) $display("FAIL bw_target_addr: got %h want %h", mi.addr, target); else passed++;
        checks++;
      end
      if (if_valid) begin
        done = 1'b1;
        if (instruction_pc !== target) $display("FAIL bw_first_pc: got %h want %h", instruction_pc, target); else passed++;
        checks++;
        if (instruction !== target + 16'h1000) $display("FAIL bw_first_instr: got %h want %h", instruction, target + 16'h1000); else passed++;
        checks++;
      end
    end
    if (!done) $display("FAIL bw_timeout: got no valid want valid"); else passed++;
    checks++;
    exp_pc = target + 16'd1;
  endtask

  task automatic test_wrap();
    bit          found = 1'b0;
    bit          seen_req = 1'b0;
    bit          done = 1'b0;
    logic [15:0] off16;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b0; #1;
      if (if_valid) found = 1'b1;
    end
    if (instruction_pc !== exp_pc) $display("FAIL wrap_pre_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
    checks++;
    off16 = 16'hFFFE - exp_pc;
    branch_taken = 1'b1;
    branch_offset_imm = off16[5:0];
    @(posedge clk); #1; branch_taken = 1'b0; #1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (i != 0) begin
        @(posedge clk); #2;
      end
      if (if_valid) found = 1'b1;
    end
    if (instruction_pc !== 16'hFFFF) $display("FAIL wrap_ffff_pc: got %h want FFFF", instruction_pc); else passed++;
    checks++;
    if (instruction !== 16'h0FFF) $display("FAIL wrap_ffff_instr: got %h want 0FFF", instruction); else passed++;
    checks++;
    branch_taken = 1'b1;
    branch_offset_imm = 6'b000001;
    @(posedge clk); #1; branch_taken = 1'b0; #1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i != 0) begin
        @(posedge clk); #2;
      end
      if (mi.req && !seen_req) begin
        seen_req = 1'b1;
        if (mi.addr !== 16'h0001) $display("FAIL wrap_target_addr: got %h want 0001", mi.addr); else passed++;
        checks++;
      end
      if (if_valid) begin
        done = 1'b1;
        if (instruction_pc !== 16'h0001) $display("FAIL wrap_post_pc: got %h want 0001", instruction_pc); else passed++;
        checks++;
        if (instruction !== 16'h1001) $display("FAIL wrap_post_instr: got %h want 1001", instruction); else passed++;
        checks++;
      end
    end
    if (!done) $display("FAIL wrap_timeout: got no valid want valid"); else passed++;
    checks++;
  endtask

  task automatic test_reset_wait();
    bit found = 1'b0;
    int got = 0;
    lat = 4;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1; instruction_decode_en = 1'b0; #1;
      if (mi.req) found = 1'b1;
    end
    if (!found) $display("FAIL rw_find: got no request want request"); else passed++;
    checks++;
    @(posedge clk); #1; rst = 1'b1; mi.gnt = 1'b0; #1;
    if (mi.req !== 1'b0) $display("FAIL rw_rst_req: got %b want 0", mi.req); else passed++;
    checks++;
    if (if_valid !== 1'b0) $display("FAIL rw_rst_valid: got %b want 0", if_valid); else passed++;
    checks++;
    @(posedge clk); #2;
    @(posedge clk); #1; rst = 1'b0; #1;
    if (mi.req !== 1'b1) $display("FAIL rw_first_req: got %b want 1", mi.req); else passed++;
    checks++;
    if (mi.addr !== 16'h0000) $display("FAIL rw_first_addr: got %h want 0000", mi.addr); else passed++;
    checks++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #2;
      if (if_valid !== 1'b0) $display("FAIL rw_stale_valid: got %b want 0", if_valid); else passed++;
      checks++;
    end
    @(posedge clk); #1; mi.gnt = 1'b1; lat = 1; #1;
    exp_pc = 16'h0000;
    for (int i = 0; i < 20 && got < 2; i++) begin
      if (i != 0) begin
        @(posedge clk); #2;
      end
      if (if_valid) begin
        if (instruction_pc !== exp_pc) $display("FAIL rw_post_pc: got %h want %h", instruction_pc, exp_pc); else passed++;
        checks++;
        if (instruction !== exp_pc + 16'h1000) $display("FAIL rw_post_instr: got %h want %h", instruction, exp_pc + 16'h1000); else passed++;
        checks++;
        exp_pc = exp_pc + 16'd1;
        got++;
      end
    end
    if (got != 2) $display("FAIL rw_post_count: got %0d want 2", got); else passed++;
    checks++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_branch_wait();
    test_wrap();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
